// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-stage bus between the PC sequencer and its surroundings
// (PC adder, instruction memory, IF/ID register, hazard and redirect logic).
//
// Signals:
//   PCAddResult  in  to sequencer : PC+4 from the external adder
//   Stall        in  to sequencer : hazard-unit hold request
//   FetchReady   in  to sequencer : IF/ID can take an instruction this cycle
//   BranchTaken / BranchTarget    : taken-branch redirect and destination
//   Jump / JumpTarget             : jump redirect and destination
//   PCResult     out of sequencer : current PC
//   FetchValid   out of sequencer : PCResult addresses a valid fetch
//   FlushIFID    out of sequencer : one-cycle squash pulse for IF/ID
//   Misaligned   out of sequencer : sticky misaligned-redirect trap flag
//   FetchCount   out of sequencer : number of accepted fetches
//   state        out of sequencer : FSM state for observation (0 BOOT, 1 RUN, 2 TRAP)
//
// Handshake: a fetch is accepted on a rising edge when FetchValid=1,
// FetchReady=1 and Stall=0 all hold in the cycle before that edge. FetchValid
// never depends on FetchReady; redirects are not part of the handshake and
// are taken whenever the sequencer is running.
interface pc_fetch_sequencer_if #(
  parameter int COUNT_W = 32
);
  logic [31:0]        PCAddResult;
  logic               Stall;
  logic               FetchReady;
  logic               BranchTaken;
  logic [31:0]        BranchTarget;
  logic               Jump;
  logic [31:0]        JumpTarget;
  logic [31:0]        PCResult;
  logic               FetchValid;
  logic               FlushIFID;
  logic               Misaligned;
  logic [COUNT_W-1:0] FetchCount;
  logic [1:0]         state;

  // master: the sequencer itself
  modport master (
    input  PCAddResult, Stall, FetchReady, BranchTaken, BranchTarget,
           Jump, JumpTarget,
    output PCResult, FetchValid, FlushIFID, Misaligned, FetchCount, state
  );

  // slave: the pipeline logic around it
  modport slave (
    output PCAddResult, Stall, FetchReady, BranchTaken, BranchTarget,
           Jump, JumpTarget,
    input  PCResult, FetchValid, FlushIFID, Misaligned, FetchCount, state
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter fetch sequencer. Owns the architectural PC, selects the
// next PC from jump, branch or sequential (PC+4) sources, holds under stall
// or backpressure, traps on misaligned redirect targets, pulses an IF/ID
// flush after every redirect and counts accepted fetches.
//
// Ports:
//   Clk    : rising-edge clock
//   Reset  : asynchronous active-low reset
//   bus    : pc_fetch_sequencer_if.master (see interface for signal list)
//
// All outputs are registers; there is no combinational path from any input
// to any output.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  pc_fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t             state_q;
  logic [31:0]        pc_q;
  logic               valid_q;
  logic               flush_q;
  logic               mis_q;
  logic [COUNT_W-1:0] count_q;

  logic        accept;
  logic        redirect;
  logic [31:0] target;

  // valid_q is only ever 1 in RUN, so accept is automatically 0 in BOOT/TRAP.
  assign accept   = valid_q & bus.FetchReady & ~bus.Stall;
  assign redirect = bus.Jump | bus.BranchTaken;
  // Jump outranks a simultaneous taken branch.
  assign target   = bus.Jump ? bus.JumpTarget : bus.BranchTarget;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      count_q <= '0;
    end else begin
      flush_q <= 1'b0;
      // Counting follows the handshake alone, independent of any redirect.
      if (accept) begin
        count_q <= count_q + COUNT_W'(1);
      end
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (redirect) begin
            // Redirects ignore Stall/FetchReady and always flush IF/ID.
            flush_q <= 1'b1;
            if (target[1:0] != 2'b00) begin
              state_q <= TRAP;
              valid_q <= 1'b0;
              mis_q   <= 1'b1;
            end else begin
              pc_q <= target;
            end
          end else if (accept) begin
            // Sequential path is never alignment-checked; wraps naturally.
            pc_q <= bus.PCAddResult;
          end
        end
        TRAP: begin
          // Frozen until reset.
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= TRAP;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PCResult   = pc_q;
  assign bus.FetchValid = valid_q;
  assign bus.FlushIFID  = flush_q;
  assign bus.Misaligned = mis_q;
  assign bus.FetchCount = count_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

  localparam int CW = 32;
  localparam int EW = 32 + 3 + CW;

  logic Clk;
  logic Reset;

  pc_fetch_sequencer_if #(.COUNT_W(CW)) bus ();

  pc_fetch_sequencer #(.RESET_PC(32'h0000_0000), .COUNT_W(CW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // External PC+4 adder.
  assign bus.PCAddResult = bus.PCResult + 32'd4;

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  // ---------------- reference model ----------------
  // Expected architectural view after each edge.
  logic [31:0]   m_pc;
  logic          m_valid, m_flush, m_mis;
  logic [CW-1:0] m_cnt;
  bit            m_boot, m_trap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 0; m_flush = 0; m_mis = 0; m_cnt = '0;
    m_boot = 1; m_trap = 0;
  endtask

  // Apply one clock's worth of inputs to the model.
  task automatic model_edge(input bit st, input bit fr, input bit b, input logic [31:0] bt,
                            input bit j, input logic [31:0] jt);
    bit acc;
    logic [31:0] tgt;
    acc = m_valid && fr && !st;
    m_flush = 0;
    if (acc) m_cnt = m_cnt + 1;
    if (m_boot) begin
      m_boot = 0; m_valid = 1;
    end else if (!m_trap) begin
      if (j || b) begin
        tgt = j ? jt : bt;
        m_flush = 1;
        if (tgt % 4 != 0) begin
          m_trap = 1; m_mis = 1; m_valid = 0;
        end else begin
          m_pc = tgt;
        end
      end else if (acc) begin
        m_pc = m_pc + 4;
      end
    end
  endtask

  function automatic logic [EW-1:0] model_pack();
    return {m_pc, m_valid, m_flush, m_mis, m_cnt};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",         64'(bus.PCResult),   64'(e[EW-1 -: 32]));
        chk("fetch_valid", 64'(bus.FetchValid), 64'(e[CW+2]));
        chk("flush",      64'(bus.FlushIFID),  64'(e[CW+1]));
        chk("misaligned", 64'(bus.Misaligned), 64'(e[CW]));
        chk("count",      64'(bus.FetchCount), 64'(e[CW-1:0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left at posedge+2.
  task automatic step(input bit st, input bit fr, input bit b, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt);
    bus.Stall = st; bus.FetchReady = fr;
    bus.BranchTaken = b; bus.BranchTarget = bt;
    bus.Jump = j; bus.JumpTarget = jt;
    model_edge(st, fr, b, bt, j, jt);
    @(posedge Clk);
    exp_q.push_back(model_pack());
    #2;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
  endtask

  task automatic idle();
    bus.Stall = 0; bus.FetchReady = 0; bus.BranchTaken = 0;
    bus.BranchTarget = 0; bus.Jump = 0; bus.JumpTarget = 0;
  endtask

  // Asserts reset between edges, checks the asynchronous effect, then
  // releases it so the next edge is the BOOT edge.
  task automatic do_reset();
    Reset = 1'b0;
    #1;
    chk("rst_pc",    64'(bus.PCResult),   64'h0);
    chk("rst_valid", 64'(bus.FetchValid), 64'h0);
    chk("rst_flush", 64'(bus.FlushIFID),  64'h0);
    chk("rst_mis",   64'(bus.Misaligned), 64'h0);
    chk("rst_count", 64'(bus.FetchCount), 64'h0);
    model_reset();
    @(posedge Clk);
    #2;
    Reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] t1, t2;
    idle();
    Reset = 1'b0;
    @(posedge Clk);
    #2;
    do_reset();

    // Sequential fetch from reset: BOOT edge then four accepts.
    step(0, 1, 0, 0, 0, 0);
    chk("boot_valid", 64'(bus.FetchValid), 64'h1);
    chk("boot_pc",    64'(bus.PCResult),   64'h0);
    run_n(4);
    chk("seq_pc",    64'(bus.PCResult),   64'h10);
    chk("seq_count", 64'(bus.FetchCount), 64'h4);

    // Hold: stall 3, backpressure 2, then release.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0);
    chk("hold_pc",    64'(bus.PCResult),   64'h10);
    chk("hold_count", 64'(bus.FetchCount), 64'h4);
    step(0, 1, 0, 0, 0, 0);
    chk("release_pc", 64'(bus.PCResult), 64'h14);

    // Redirect priority under stall at PC 0x20.
    step(1, 0, 0, 0, 1, 32'h20);
    step(1, 1, 1, 32'h80, 1, 32'h400);
    chk("prio_pc",    64'(bus.PCResult),   64'h400);
    chk("prio_flush", 64'(bus.FlushIFID),  64'h1);
    chk("prio_count", 64'(bus.FetchCount), 64'h5);
    // Back-to-back redirect, then flush must drop.
    step(0, 1, 1, 32'h200, 0, 0);
    chk("b2b_flush", 64'(bus.FlushIFID), 64'h1);
    step(1, 1, 0, 0, 0, 0);
    chk("flush_drop", 64'(bus.FlushIFID), 64'h0);

    // Misaligned trap.
    step(0, 1, 1, 32'h102, 0, 0);
    chk("trap_pc",    64'(bus.PCResult),   64'h200);
    chk("trap_mis",   64'(bus.Misaligned), 64'h1);
    chk("trap_valid", 64'(bus.FetchValid), 64'h0);
    step(0, 1, 0, 0, 1, 32'h800);
    chk("trap_frozen", 64'(bus.PCResult), 64'h200);
    chk("trap_noflush", 64'(bus.FlushIFID), 64'h0);
    do_reset();

    // Wrap-around.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFF8);
    chk("wrap_start", 64'(bus.PCResult), 64'hFFFF_FFF8);
    run_n(2);
    chk("wrap_pc",  64'(bus.PCResult),   64'h0);
    chk("wrap_mis", 64'(bus.Misaligned), 64'h0);

    // Async reset mid-flush at PC 0x3C.
    step(0, 1, 0, 0, 1, 32'h3C);
    chk("pre_rst_flush", 64'(bus.FlushIFID), 64'h1);
    do_reset();

    // Randomized phase against the model.
    for (int n = 0; n < 600; n++) begin
      t1 = $urandom;
      t2 = $urandom;
      t1[1:0] = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      t2[1:0] = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ((m_trap && $urandom_range(0, 4) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 7) == 0, t1, $urandom_range(0, 9) == 0, t2);
      end
    end

    idle();
    @(posedge Clk);
    #3;
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
